// File: rtl/axi4lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns a command/response port into one AXI4-Lite
// write or read at a time, with a per-transaction timeout for slaves that never answer.
module axi4lite_cmd_master #(
    parameter int unsigned AW        = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned TO_CYCLES = 256
) (
    input  logic            ACLK,
    input  logic            ARESET,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [AW-1:0]   cmd_addr,
    input  logic [DW-1:0]   cmd_wdata,
    input  logic [DW/8-1:0] cmd_wstrb,

    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic [1:0]      rsp_resp,
    output logic            rsp_timeout,

    output logic [AW-1:0]   AWADDR,
    output logic            AWVALID,
    input  logic            AWREADY,
    output logic [DW-1:0]   WDATA,
    output logic [DW/8-1:0] WSTRB,
    output logic            WVALID,
    input  logic            WREADY,
    input  logic [1:0]      BRESP,
    input  logic            BVALID,
    output logic            BREADY,
    output logic [AW-1:0]   ARADDR,
    output logic            ARVALID,
    input  logic            ARREADY,
    input  logic [DW-1:0]   RDATA,
    input  logic [1:0]      RRESP,
    input  logic            RVALID,
    output logic            RREADY
);

    localparam int unsigned CntW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES + 1) : 1;
    // Counter value during the last in-flight cycle; the timeout fires on the following edge.
    localparam logic [CntW-1:0] ToLast = (TO_CYCLES == 0) ? '0 : CntW'(TO_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWb,
        StRa,
        StRd,
        StRsp
    } state_e;

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [AW-1:0]     awaddr_q, awaddr_d;
    logic              awvalid_q, awvalid_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wstrb_q, wstrb_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic [AW-1:0]     araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [CntW-1:0]   to_cnt_q, to_cnt_d;

    logic busy;
    logic to_hit;
    logic aw_done;
    logic w_done;

    assign busy    = (state_q == StWr) || (state_q == StWb) ||
                     (state_q == StRa) || (state_q == StRd);
    assign to_hit  = (TO_CYCLES != 0) && (to_cnt_q == ToLast);
    // A channel is finished if it already handshook or is handshaking this cycle.
    assign aw_done = !awvalid_q || AWREADY;
    assign w_done  = !wvalid_q || WREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q       <= StIdle;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= 2'b00;
            rsp_timeout_q <= 1'b0;
            awaddr_q      <= '0;
            awvalid_q     <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            araddr_q      <= '0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            awaddr_q      <= awaddr_d;
            awvalid_q     <= awvalid_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            araddr_q      <= araddr_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            to_cnt_q      <= to_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        awaddr_d      = awaddr_q;
        awvalid_d     = awvalid_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        araddr_d      = araddr_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        to_cnt_d      = busy ? to_cnt_q + CntW'(1) : to_cnt_q;

        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    to_cnt_d    = '0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = StWr;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = StRa;
                    end
                end
            end
            StWr: begin
                awvalid_d = awvalid_q && !AWREADY;
                wvalid_d  = wvalid_q && !WREADY;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = StWb;
                end
            end
            StWb: begin
                if (BVALID) begin
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_resp_d    = BRESP;
                    rsp_timeout_d = 1'b0;
                    state_d       = StRsp;
                end
            end
            StRa: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRd;
                end
            end
            StRd: begin
                if (RVALID) begin
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = RDATA;
                    rsp_resp_d    = RRESP;
                    rsp_timeout_d = 1'b0;
                    state_d       = StRsp;
                end
            end
            StRsp: begin
                cmd_ready_d = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Timeout overrides whatever the channel logic decided on the same edge.
        if (busy && to_hit) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = 2'b10;
            rsp_timeout_d = 1'b1;
            state_d       = StRsp;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign rsp_timeout = rsp_timeout_q;
    assign AWADDR      = awaddr_q;
    assign AWVALID     = awvalid_q;
    assign WDATA       = wdata_q;
    assign WSTRB       = wstrb_q;
    assign WVALID      = wvalid_q;
    assign BREADY      = bready_q;
    assign ARADDR      = araddr_q;
    assign ARVALID     = arvalid_q;
    assign RREADY      = rready_q;

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Bench for axi4lite_cmd_master: directed and random transactions against a slave whose
// handshake delays are chosen per transaction; expected bus timing is derived from those delays.
module tb_axi4lite_cmd_master;

    localparam int TO = 8;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [3:0]  AWADDR;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [3:0]  ARADDR;
    logic        ARVALID;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;

    int n_checks = 0;
    int n_fail   = 0;

    logic [85:0] all_outs;
    assign all_outs = {cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, AWADDR, AWVALID,
                       WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY};

    axi4lite_cmd_master #(
        .AW        (4),
        .DW        (32),
        .TO_CYCLES (TO)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .rsp_timeout (rsp_timeout),
        .AWADDR      (AWADDR),
        .AWVALID     (AWVALID),
        .AWREADY     (AWREADY),
        .WDATA       (WDATA),
        .WSTRB       (WSTRB),
        .WVALID      (WVALID),
        .WREADY      (WREADY),
        .BRESP       (BRESP),
        .BVALID      (BVALID),
        .BREADY      (BREADY),
        .ARADDR      (ARADDR),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RDATA       (RDATA),
        .RRESP       (RRESP),
        .RVALID      (RVALID),
        .RREADY      (RREADY)
    );

    initial forever #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic slave_idle();
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BRESP   = 2'b00;
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RDATA   = 32'h0;
        RRESP   = 2'b00;
    endtask

    // Called just after a falling edge; returns just after the falling edge of the cycle in which
    // cmd_ready is high again. Cycle c is the clock period following the c-th edge after accept.
    // d_r < 0 means the slave never sends B/R.
    task automatic run_txn(input bit wr, input logic [3:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int d_a, input int d_w, input int d_r,
                           input logic [1:0] resp, input logic [31:0] rd, input bit hold,
                           input bit b2b);
        int          a_e, w_e, rdy_s, d_e, e_end, wc;
        bit          tmo, a_done, w_done, d_done;
        logic [6:0]  exp_ctrl;
        logic [31:0] e_rdata, junk;
        logic [1:0]  e_resp;

        a_e     = 1 + d_a;
        w_e     = wr ? 1 + d_w : 0;
        rdy_s   = ((a_e > w_e) ? a_e : w_e) + 1;
        d_e     = (d_r < 0) ? 1000 : rdy_s + d_r;
        tmo     = (d_e >= TO);
        e_end   = tmo ? TO : d_e;
        e_resp  = tmo ? 2'b10 : resp;
        e_rdata = (tmo || wr) ? 32'h0 : rd;
        a_done  = 1'b0;
        w_done  = 1'b0;
        d_done  = 1'b0;

        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_wstrb = ws;
        cmd_valid = 1'b1;
        wc = 0;
        while (!cmd_ready && wc < 20) begin
            @(negedge ACLK);
            wc++;
        end
        if (!cmd_ready) begin
            check_eq("accept", 1'b0, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        if (b2b) check_eq("b2b_wait", wc, 0);
        @(negedge ACLK);
        if (!hold) cmd_valid = 1'b0;

        for (int c = 1; c <= e_end + 2; c++) begin
            exp_ctrl[6] = wr && c <= a_e && c <= e_end;
            exp_ctrl[5] = wr && c <= w_e && c <= e_end;
            exp_ctrl[4] = wr && c >= rdy_s && c <= e_end;
            exp_ctrl[3] = !wr && c <= a_e && c <= e_end;
            exp_ctrl[2] = !wr && c >= rdy_s && c <= e_end;
            exp_ctrl[1] = (c == e_end + 2);
            exp_ctrl[0] = (c == e_end + 1);
            check_eq($sformatf("ctrl_c%0d", c),
                     {AWVALID, WVALID, BREADY, ARVALID, RREADY, cmd_ready, rsp_valid}, exp_ctrl);
            if (exp_ctrl[6]) check_eq($sformatf("awaddr_c%0d", c), AWADDR, addr);
            if (exp_ctrl[5]) check_eq($sformatf("wdata_c%0d", c), {WDATA, WSTRB}, {wd, ws});
            if (exp_ctrl[3]) check_eq($sformatf("araddr_c%0d", c), ARADDR, addr);
            if (c == e_end + 1)
                check_eq("rsp", {rsp_rdata, rsp_resp, rsp_timeout}, {e_rdata, e_resp, tmo});

            if (wr) begin
                AWREADY = !a_done && c >= a_e;
                if (AWVALID && AWREADY) a_done = 1'b1;
                WREADY = !w_done && c >= w_e;
                if (WVALID && WREADY) w_done = 1'b1;
                BVALID = !d_done && c >= d_e;
                BRESP  = resp;
                if (BVALID && BREADY) d_done = 1'b1;
            end else begin
                ARREADY = !a_done && c >= a_e;
                if (ARVALID && ARREADY) a_done = 1'b1;
                junk   = $urandom;
                RVALID = !d_done && c >= d_e;
                RRESP  = resp;
                RDATA  = RVALID ? rd : junk;
                if (RVALID && RREADY) d_done = 1'b1;
            end
            if (c < e_end + 2) @(negedge ACLK);
        end
        slave_idle();
    endtask

    initial begin
        int          wc;
        bit          prev_hold;
        bit          r_wr, r_hold;
        logic [31:0] r1, r2, r3;
        int          r_da, r_dw, r_dr;

        ARESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        slave_idle();
        #2;
        check_eq("reset_outs", all_outs, 128'h0);
        @(negedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        check_eq("ready_pre", cmd_ready, 1'b0);
        @(negedge ACLK);
        check_eq("ready_post", cmd_ready, 1'b1);

        // Zero-wait write, write with late W, delayed-address read with SLVERR.
        run_txn(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 32'h0, 1'b0, 1'b0);
        run_txn(1'b1, 4'hC, 32'hCAFE0123, 4'h5, 0, 3, 0, 2'b00, 32'h0, 1'b0, 1'b0);
        run_txn(1'b0, 4'h8, 32'h0, 4'h0, 2, 0, 0, 2'b10, 32'h12345678, 1'b0, 1'b0);
        // Silent slaves: write and read timeouts.
        run_txn(1'b1, 4'h0, 32'hA5A5A5A5, 4'h3, 0, 0, -1, 2'b00, 32'h0, 1'b0, 1'b0);
        run_txn(1'b0, 4'h6, 32'h0, 4'h0, 1, 0, -1, 2'b00, 32'h55AA55AA, 1'b0, 1'b0);
        // Back-to-back with cmd_valid held high throughout.
        run_txn(1'b1, 4'h1, 32'h11111111, 4'hF, 0, 0, 0, 2'b01, 32'h0, 1'b1, 1'b0);
        run_txn(1'b0, 4'h2, 32'h0, 4'h0, 0, 0, 0, 2'b11, 32'h22222222, 1'b1, 1'b1);
        run_txn(1'b1, 4'h3, 32'h33333333, 4'h8, 1, 0, 1, 2'b00, 32'h0, 1'b0, 1'b1);

        // Reset pulsed while waiting in RD.
        cmd_write = 1'b0;
        cmd_addr  = 4'h2;
        cmd_valid = 1'b1;
        wc = 0;
        while (!cmd_ready && wc < 20) begin
            @(negedge ACLK);
            wc++;
        end
        check_eq("rst_accept", cmd_ready, 1'b1);
        @(negedge ACLK);
        cmd_valid = 1'b0;
        ARREADY   = 1'b1;
        @(negedge ACLK);
        ARREADY = 1'b0;
        check_eq("rst_rready_pre", RREADY, 1'b1);
        #2 ARESET = 1'b1;
        #1;
        check_eq("rst_async", all_outs, 128'h0);
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        check_eq("rst_release", {cmd_ready, rsp_valid}, 2'b00);
        @(negedge ACLK);
        check_eq("rst_ready", {cmd_ready, rsp_valid}, 2'b10);

        // Random traffic; some delays deliberately run past the timeout.
        prev_hold = 1'b0;
        for (int i = 0; i < 40; i++) begin
            r1     = $urandom;
            r2     = $urandom;
            r3     = $urandom;
            r_wr   = r3[0];
            r_hold = r3[1];
            r_da   = int'($urandom_range(0, 2));
            r_dw   = int'($urandom_range(0, 3));
            r_dr   = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            run_txn(r_wr, r1[3:0], r2, r1[7:4], r_da, r_dw, r_dr, r3[3:2], r1, r_hold,
                    prev_hold);
            prev_hold = r_hold;
        end
        cmd_valid = 1'b0;
        @(negedge ACLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4lite_cmd_master.md
Name: axi4lite_cmd_master

Overview:
- Single-outstanding AXI4-Lite master. It converts a simple command/response port into AXI4-Lite write and read transactions.
- Used by on-chip sequencers and test logic to configure the timer register block, or any other AXI4-Lite slave.
- Sequences the address, data, response and read channels with an FSM, and flags slaves that never respond via a per-transaction timeout.

Parameters:
AW, 4, address width (byte address)
DW, 32, data width; WSTRB width is DW/8
TO_CYCLES, 256, cycles a transaction may stay in flight before timeout; 0 disables the timeout

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AW  target address
cmd_wdata  in  DW  write data
cmd_wstrb  in  DW/8  write byte strobes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DW  read data (0 for writes)
rsp_resp  out  2  BRESP/RRESP as received
rsp_timeout  out  1  transaction timed out
AWADDR  out  AW  write address
AWVALID  out  1
AWREADY  in  1
WDATA  out  DW
WSTRB  out  DW/8
WVALID  out  1
WREADY  in  1
BRESP  in  2
BVALID  in  1
BREADY  out  1
ARADDR  out  AW
ARVALID  out  1
ARREADY  in  1
RDATA  in  DW
RRESP  in  2
RVALID  in  1
RREADY  out  1

Behaviour:
- All outputs are registered.
- Reset values: every VALID/READY output 0; cmd_ready 0; rsp_* 0; address/data outputs 0; state IDLE; timeout counter 0.
- cmd_ready goes to 1 on the first ACLK edge after ARESET deasserts.
- States: IDLE, WR (AW+W), WB, RA, RD, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch cmd_*, drop cmd_ready, and go to WR if cmd_write else RA.
  - AWVALID+WVALID (or ARVALID) assert the next cycle.
- WR:
  - AWVALID and WVALID assert together.
  - Each deasserts independently on its own handshake (VALID&&READY), in any order or in the same cycle.
  - Once both handshakes are done, go to WB with BREADY=1.
- WB: on BVALID, capture BRESP and drop BREADY, then go to RSP.
- RA: ARVALID until ARREADY, then go to RD with RREADY=1.
- RD: on RVALID, capture RDATA/RRESP and drop RREADY, then go to RSP.
- RSP:
  - rsp_valid=1 for exactly one cycle, with rsp_rdata, rsp_resp and rsp_timeout valid that cycle.
  - The response has no backpressure.
  - Next state is IDLE with cmd_ready=1.
- Minimum latency with a zero-wait slave: command accepted at edge 0, VALIDs at cycle 1, B/R handshake at cycle 2, rsp_valid at cycle 3, cmd_ready high again at cycle 4.
- VALID outputs never deassert before their handshake, and address/data stay stable while VALID is high.
- Timeout:
  - The counter clears on command accept and increments every cycle in WR/WB/RA/RD.
  - If TO_CYCLES!=0 and the counter reaches TO_CYCLES, all VALID/READY outputs drop and the FSM goes to RSP with rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0.
  - Any late B/R from the slave is not accepted; the system must reset the slave.
- Non-OKAY responses (SLVERR/DECERR) are passed through with rsp_timeout=0.
- ARESET mid-transaction: outputs return to their reset values immediately (asynchronously), and the latched command is discarded.
- cmd_valid while cmd_ready=0 is ignored; the requester holds it until accepted.

Test Plan:
- Write 0x4←0xDEADBEEF, strobe 0xF, AWREADY=WREADY=1, BVALID one cycle later with OKAY → AWADDR=0x4 and WDATA=0xDEADBEEF at cycle 1; rsp_valid at cycle 3 with rsp_resp=0 and rsp_timeout=0.
- Write with WREADY 3 cycles after AWREADY → AWVALID drops after its own handshake while WVALID stays high with stable WDATA; BREADY asserts only after both handshakes.
- Read 0x8 with RDATA=0x12345678, RRESP=SLVERR, ARREADY delayed 2 cycles → ARADDR held stable; rsp_rdata=0x12345678, rsp_resp=2'b10.
- TO_CYCLES=8 and the slave never asserts BVALID → exactly 8 cycles after accept, all bus VALID/READY outputs are 0; one rsp_valid pulse with rsp_timeout=1, rsp_resp=2'b10; cmd_ready=1 the following cycle.
- ARESET pulsed during RD → RREADY=0 and cmd_ready=0 immediately; cmd_ready=1 one cycle after release; no rsp_valid.
- Back-to-back commands, cmd_valid held high → second command accepted exactly 1 cycle after the first rsp_valid; no overlap of transactions on the bus.
